axi_lite_master: RTL and testbench
==================================

// Module: axi_lite_master
// PURPOSE
//  AXI4-Lite initiator: converts a simple valid/ready command port into AW/W/B or AR/R
//  transactions toward the AXI-Lite slave memory, and returns read data and response.
//  Counterpart to the slave block. Sits between a test/CPU-side command source and the bus.
//  One outstanding transaction at a time. All bus outputs are registered.
// PARAMETERS
//  ADDR_W     32      address width (AWADDR/ARADDR/cmd_addr)
//  DATA_W     32      data width; STRB_W = DATA_W/8
//  ERR_CNT_W  8       width of saturating error-response counter
//  PROT       3'b000  constant driven on AWPROT/ARPROT
// PORTS
//  ACLK        in   1        clock, all logic on rising edge
//  ARESETN     in   1        asynchronous active-low reset
//  cmd_valid   in   1        command request
//  cmd_ready   out  1        command accepted when cmd_valid&&cmd_ready
//  cmd_write   in   1        1=write, 0=read
//  cmd_addr    in   ADDR_W   byte address
//  cmd_wdata   in   DATA_W   write data
//  cmd_wstrb   in   STRB_W   write byte strobes
//  rsp_valid   out  1        response available
//  rsp_ready   in   1        response consumer ready
//  rsp_rdata   out  DATA_W   read data (0 for writes)
//  rsp_resp    out  2        BRESP or RRESP of completed transaction
//  rsp_write   out  1        echoes cmd_write of completed transaction
//  err_cnt     out  ERR_CNT_W count of SLVERR/DECERR responses, saturating
//  AWVALID/AWREADY/AWADDR[ADDR_W]/AWPROT[3]   out/in/out/out  write-address channel
//  WVALID/WREADY/WDATA[DATA_W]/WSTRB[STRB_W]  out/in/out/out  write-data channel
//  BVALID/BREADY/BRESP[2]                     in/out/in       write-response channel
//  ARVALID/ARREADY/ARADDR[ADDR_W]/ARPROT[3]   out/in/out/out  read-address channel
//  RVALID/RREADY/RDATA[DATA_W]/RRESP[2]       in/out/in/in    read-data channel
// BEHAVIOUR
//  Reset: all VALID/READY outputs 0, rsp_valid 0, rsp_rdata 0, rsp_resp 0, err_cnt 0,
//   addr/data/strb outputs 0, state IDLE. Reset mid-transaction abandons it immediately.
//  FSM: IDLE -> WR_REQ -> WR_RESP -> RSP -> IDLE (write); IDLE -> RD_REQ -> RD_DATA -> RSP -> IDLE (read).
//  IDLE: cmd_ready=1 (only state where it is 1). On accept, latch addr/data/strb/write;
//   next cycle AWVALID=WVALID=1 (write) or ARVALID=1 (read). Latency cmd accept -> VALID: 1 cycle.
//  WR_REQ: AW and W tracked independently (aw_done, w_done). Each VALID held with stable
//   payload until its own handshake, then deasserted next cycle. Both may complete same
//   cycle or in either order; when both done -> WR_RESP.
//  WR_RESP: BREADY=1; on BVALID&&BREADY capture BRESP, BREADY->0, go RSP.
//  RD_REQ: ARVALID held until ARREADY; then RD_DATA. RD_DATA: RREADY=1; on RVALID&&RREADY
//   capture RDATA/RRESP, go RSP.
//  RSP: rsp_valid=1 with stable payload until rsp_ready; then IDLE. Earliest new cmd accept
//   is the cycle after rsp handshake. rsp_valid asserts 1 cycle after B/R handshake.
//  VALIDs never depend combinationally on READYs; no VALID is withdrawn before handshake.
//  err_cnt increments when captured resp[1]==1 (SLVERR/DECERR); saturates at all-ones.
//  Write transactions return rsp_rdata=0. PROT is constant. No timeout: waits indefinitely.
// STRUCTURE
//  Shared package axi_lite_pkg: RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10,
//   RESP_DECERR=2'b11, master FSM state encoding (one-hot).
//  Single module; optional sub-module axi_lite_master_wr (AW/W/B sequencing) if split.
// TESTING
//  1 write 0x04 data 0xDEADBEEF strb 0xF, AWREADY delayed 3 cyc, WREADY immediate -> W done
//    first, AWVALID held 3 cyc stable, rsp_resp=0, rsp_write=1, rsp_rdata=0.
//  2 read 0x04 after test 1, ARREADY 0 cyc, RVALID after 2 cyc -> rsp_rdata=0xDEADBEEF, resp=0.
//  3 write strb 0x3 data 0x12345678 to 0x08, read 0x08 -> rsp_rdata=0x00005678 (mem pre-zeroed).
//  4 slave returns BRESP=2'b10 then RRESP=2'b11 -> rsp_resp matches, err_cnt=2; 300 errors
//    with ERR_CNT_W=8 -> err_cnt=255.
//  5 rsp_ready held 0 for 5 cyc -> rsp_valid/payload stable, cmd_ready=0 throughout.
//  6 ARESETN low while AWVALID high -> next sample all VALIDs 0, state IDLE, cmd_ready=1 after release.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and the one-hot master state encoding.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [5:0] {
        ST_IDLE    = 6'b000001,
        ST_WR_REQ  = 6'b000010,
        ST_WR_RESP = 6'b000100,
        ST_RD_REQ  = 6'b001000,
        ST_RD_DATA = 6'b010000,
        ST_RSP     = 6'b100000
    } mst_state_e;

endpackage

// File: rtl/axi_lite_master.sv
// AXI4-Lite initiator: turns one valid/ready command at a time into an AW/W/B or AR/R
// transaction and returns the captured response; every bus-facing output is a flop.
module axi_lite_master
    import axi_lite_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ERR_CNT_W = 8,
    parameter logic [2:0]  PROT      = 3'b000
) (
    input  logic                   ACLK,
    input  logic                   ARESETN,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_write,
    input  logic [ADDR_W-1:0]      cmd_addr,
    input  logic [DATA_W-1:0]      cmd_wdata,
    input  logic [DATA_W/8-1:0]    cmd_wstrb,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DATA_W-1:0]      rsp_rdata,
    output logic [1:0]             rsp_resp,
    output logic                   rsp_write,
    output logic [ERR_CNT_W-1:0]   err_cnt,
    output logic                   AWVALID,
    input  logic                   AWREADY,
    output logic [ADDR_W-1:0]      AWADDR,
    output logic [2:0]             AWPROT,
    output logic                   WVALID,
    input  logic                   WREADY,
    output logic [DATA_W-1:0]      WDATA,
    output logic [DATA_W/8-1:0]    WSTRB,
    input  logic                   BVALID,
    output logic                   BREADY,
    input  logic [1:0]             BRESP,
    output logic                   ARVALID,
    input  logic                   ARREADY,
    output logic [ADDR_W-1:0]      ARADDR,
    output logic [2:0]             ARPROT,
    input  logic                   RVALID,
    output logic                   RREADY,
    input  logic [DATA_W-1:0]      RDATA,
    input  logic [1:0]             RRESP
);

    mst_state_e             state_q, state_d;
    logic                   cmd_ready_q, cmd_ready_d;
    logic                   awvalid_q, awvalid_d;
    logic                   wvalid_q, wvalid_d;
    logic                   arvalid_q, arvalid_d;
    logic                   bready_q, bready_d;
    logic                   rready_q, rready_d;
    logic [ADDR_W-1:0]      awaddr_q, awaddr_d;
    logic [ADDR_W-1:0]      araddr_q, araddr_d;
    logic [DATA_W-1:0]      wdata_q, wdata_d;
    logic [DATA_W/8-1:0]    wstrb_q, wstrb_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]      rsp_rdata_q, rsp_rdata_d;
    logic [1:0]             rsp_resp_q, rsp_resp_d;
    logic                   rsp_write_q, rsp_write_d;
    logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic                   aw_done, w_done, cap_en;
    logic [1:0]             cap_resp;

    // A channel counts as done once its VALID has dropped or is handshaking now,
    // so the VALID flops double as the per-channel completion flags.
    assign aw_done = !awvalid_q || AWREADY;
    assign w_done  = !wvalid_q  || WREADY;

    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        arvalid_d   = arvalid_q;
        bready_d    = bready_q;
        rready_d    = rready_q;
        awaddr_d    = awaddr_q;
        araddr_d    = araddr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
        rsp_write_d = rsp_write_q;
        cap_en      = 1'b0;
        cap_resp    = RESP_OKAY;

        case (state_q)
            ST_IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    if (cmd_write) begin
                        awaddr_d  = cmd_addr;
                        wdata_d   = cmd_wdata;
                        wstrb_d   = cmd_wstrb;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = ST_WR_REQ;
                    end else begin
                        araddr_d  = cmd_addr;
                        arvalid_d = 1'b1;
                        state_d   = ST_RD_REQ;
                    end
                end
            end
            ST_WR_REQ: begin
                if (awvalid_q && AWREADY) awvalid_d = 1'b0;
                if (wvalid_q && WREADY)   wvalid_d  = 1'b0;
                if (aw_done && w_done) begin
                    bready_d = 1'b1;
                    state_d  = ST_WR_RESP;
                end
            end
            ST_WR_RESP: begin
                if (BVALID && bready_q) begin
                    bready_d    = 1'b0;
                    cap_en      = 1'b1;
                    cap_resp    = BRESP;
                    rsp_rdata_d = '0;
                    rsp_write_d = 1'b1;
                    state_d     = ST_RSP;
                end
            end
            ST_RD_REQ: begin
                if (arvalid_q && ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                if (RVALID && rready_q) begin
                    rready_d    = 1'b0;
                    cap_en      = 1'b1;
                    cap_resp    = RRESP;
                    rsp_rdata_d = RDATA;
                    rsp_write_d = 1'b0;
                    state_d     = ST_RSP;
                end
            end
            ST_RSP: begin
                if (rsp_valid_q && rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                cmd_ready_d = 1'b0;
                awvalid_d   = 1'b0;
                wvalid_d    = 1'b0;
                arvalid_d   = 1'b0;
                bready_d    = 1'b0;
                rready_d    = 1'b0;
                rsp_valid_d = 1'b0;
            end
        endcase

        if (cap_en) begin
            rsp_valid_d = 1'b1;
            rsp_resp_d  = cap_resp;
        end
    end

    // SLVERR and DECERR both have bit 1 set; the counter sticks at all-ones.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (cap_en && cap_resp[1] && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            bready_q    <= 1'b0;
            rready_q    <= 1'b0;
            awaddr_q    <= '0;
            araddr_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= RESP_OKAY;
            rsp_write_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            arvalid_q   <= arvalid_d;
            bready_q    <= bready_d;
            rready_q    <= rready_d;
            awaddr_q    <= awaddr_d;
            araddr_q    <= araddr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
            rsp_write_q <= rsp_write_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_resp  = rsp_resp_q;
    assign rsp_write = rsp_write_q;
    assign err_cnt   = err_cnt_q;
    assign AWVALID   = awvalid_q;
    assign AWADDR    = awaddr_q;
    assign AWPROT    = PROT;
    assign WVALID    = wvalid_q;
    assign WDATA     = wdata_q;
    assign WSTRB     = wstrb_q;
    assign BREADY    = bready_q;
    assign ARVALID   = arvalid_q;
    assign ARADDR    = araddr_q;
    assign ARPROT    = PROT;
    assign RREADY    = rready_q;

endmodule

// File: tb/tb_axi_lite_master.sv
// Bench for axi_lite_master: a small AXI-Lite memory slave with programmable stalls,
// directed commands whose expected responses go to a scoreboard queue checked by a monitor.
module tb_axi_lite_master;
    import axi_lite_pkg::*;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [7:0]  err_cnt;
    logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RVALID, RREADY;
    logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
    logic [3:0]  WSTRB;
    logic [2:0]  AWPROT, ARPROT;
    logic [1:0]  BRESP, RRESP;

    always #5 ACLK = ~ACLK;

    axi_lite_master #(.ADDR_W(32), .DATA_W(32), .ERR_CNT_W(8), .PROT(3'b000)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_write(rsp_write), .err_cnt(err_cnt),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWPROT(AWPROT),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARPROT(ARPROT),
        .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP)
    );

    typedef struct packed {
        logic        wr;
        logic [31:0] rdata;
        logic [1:0]  resp;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned n_cmp = 0;
    int unsigned n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- slave model (drives on falling edge) ----------------
    logic [31:0] mem [0:15];
    int unsigned aw_delay = 0, w_delay = 0, ar_delay = 0, r_delay = 0;
    logic [1:0]  bresp_cfg = RESP_OKAY, rresp_cfg = RESP_OKAY;
    int unsigned aw_wait, w_wait, ar_wait, r_wait, aw_hi, w_hi;
    logic        aw_have, w_have, ar_have;
    logic [31:0] aw_a, w_d, ar_a;
    logic [3:0]  w_st;
    logic        aw_v_s, w_v_s, ar_v_s, bready_s, rready_s;
    logic [31:0] aw_addr_s, w_data_s, ar_addr_s;
    logic [3:0]  w_strb_s;

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
        AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 0;
        ARREADY = 0; RVALID = 0; RDATA = 0; RRESP = 0;
        aw_hi = 0; w_hi = 0;
    end

    always @(negedge ACLK) begin
        if (!ARESETN) begin
            AWREADY = 0; WREADY = 0; BVALID = 0; ARREADY = 0; RVALID = 0;
            aw_have = 0; w_have = 0; ar_have = 0;
            aw_wait = 0; w_wait = 0; ar_wait = 0; r_wait = 0;
            aw_v_s = 0; w_v_s = 0; ar_v_s = 0; bready_s = 0; rready_s = 0;
        end else begin
            // an un-acknowledged VALID must still be up with unchanged payload
            if (aw_v_s && !AWREADY) begin
                check("awvalid_hold", AWVALID, 1);
                check("awaddr_hold", AWADDR, aw_addr_s);
            end
            if (w_v_s && !WREADY) begin
                check("wvalid_hold", WVALID, 1);
                check("wdata_hold", WDATA, w_data_s);
            end
            if (ar_v_s && !ARREADY) begin
                check("arvalid_hold", ARVALID, 1);
                check("araddr_hold", ARADDR, ar_addr_s);
            end
            if (aw_v_s && AWREADY) begin aw_have = 1; aw_a = aw_addr_s; AWREADY = 0; aw_wait = 0; end
            if (w_v_s && WREADY) begin w_have = 1; w_d = w_data_s; w_st = w_strb_s; WREADY = 0; w_wait = 0; end
            if (BVALID && bready_s) BVALID = 0;
            if (ar_v_s && ARREADY) begin ar_have = 1; ar_a = ar_addr_s; ARREADY = 0; ar_wait = 0; r_wait = 0; end
            if (RVALID && rready_s) RVALID = 0;
            if (AWVALID) aw_hi++;
            if (WVALID) w_hi++;
            if (AWVALID && !aw_have && !AWREADY) begin
                if (aw_wait >= aw_delay) AWREADY = 1; else aw_wait++;
            end
            if (WVALID && !w_have && !WREADY) begin
                if (w_wait >= w_delay) WREADY = 1; else w_wait++;
            end
            if (ARVALID && !ar_have && !ARREADY) begin
                if (ar_wait >= ar_delay) ARREADY = 1; else ar_wait++;
            end
            if (aw_have && w_have && !BVALID) begin
                if (!bresp_cfg[1])
                    for (int b = 0; b < 4; b++)
                        if (w_st[b]) mem[aw_a[5:2]][8*b +: 8] = w_d[8*b +: 8];
                BRESP = bresp_cfg; BVALID = 1; aw_have = 0; w_have = 0;
            end
            if (ar_have && !RVALID) begin
                if (r_wait >= r_delay) begin
                    RDATA = mem[ar_a[5:2]]; RRESP = rresp_cfg; RVALID = 1; ar_have = 0;
                end else r_wait++;
            end
            aw_v_s = AWVALID; aw_addr_s = AWADDR;
            w_v_s = WVALID; w_data_s = WDATA; w_strb_s = WSTRB;
            ar_v_s = ARVALID; ar_addr_s = ARADDR;
            bready_s = BREADY; rready_s = RREADY;
        end
    end

    // ---------------- response monitor ----------------
    always @(negedge ACLK) begin
        if (ARESETN && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL rsp_unexpected: got resp %0d rdata 0x%08h, no response expected", rsp_resp, rsp_rdata);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("rsp_write", rsp_write, e.wr);
                check("rsp_rdata", rsp_rdata, e.rdata);
                check("rsp_resp", rsp_resp, e.resp);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb);
        bit got;
        got = 0;
        @(posedge ACLK); #1;
        cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb; cmd_valid = 1;
        for (int i = 0; i < 200; i++) begin
            @(negedge ACLK);
            if (cmd_ready) begin got = 1; break; end
        end
        check("cmd_accept", got, 1);
        @(posedge ACLK); #1;
        cmd_valid = 0;
        if (got) begin
            if (wr) check("req_latency_aw_w", {AWVALID, WVALID}, 2'b11);
            else    check("req_latency_ar", ARVALID, 1);
        end
    endtask

    task automatic do_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input logic [31:0] exp_rdata, input logic [1:0] exp_resp);
        exp_t e;
        e.wr = wr; e.rdata = exp_rdata; e.resp = exp_resp;
        exp_q.push_back(e);
        issue(wr, addr, data, strb);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge ACLK);
        end
        check("rsp_timeout_pending", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0; rsp_ready = 1;
        repeat (3) @(negedge ACLK);
        check("rst_valids", {AWVALID, WVALID, ARVALID, BREADY, RREADY, rsp_valid}, 0);
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_rsp_resp", rsp_resp, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_awaddr", AWADDR, 0);
        check("rst_wdata", WDATA, 0);
        check("rst_wstrb", WSTRB, 0);
        check("rst_araddr", ARADDR, 0);
        check("prot", {AWPROT, ARPROT}, 0);
        @(posedge ACLK); #1 ARESETN = 1;
        repeat (2) @(negedge ACLK);
        check("idle_cmd_ready", cmd_ready, 1);

        // 1: AW stalled 3 cycles, W accepted at once
        aw_delay = 3; aw_hi = 0; w_hi = 0;
        do_cmd(1, 32'h04, 32'hDEADBEEF, 4'hF, 32'h0, RESP_OKAY);
        wait_done();
        check("t1_awvalid_cycles", aw_hi, 4);
        check("t1_wvalid_cycles", w_hi, 1);
        aw_delay = 0;

        // 2: read back with RVALID two cycles late
        r_delay = 2;
        do_cmd(0, 32'h04, 32'h0, 4'h0, 32'hDEADBEEF, RESP_OKAY);
        wait_done();
        r_delay = 0;

        // 3: partial strobes
        do_cmd(1, 32'h08, 32'h12345678, 4'h3, 32'h0, RESP_OKAY);
        wait_done();
        do_cmd(0, 32'h08, 32'h0, 4'h0, 32'h00005678, RESP_OKAY);
        wait_done();

        // 4: error responses and counter saturation
        bresp_cfg = RESP_SLVERR;
        do_cmd(1, 32'h0C, 32'hAAAA5555, 4'hF, 32'h0, RESP_SLVERR);
        wait_done();
        bresp_cfg = RESP_OKAY; rresp_cfg = RESP_DECERR;
        do_cmd(0, 32'h04, 32'h0, 4'h0, 32'hDEADBEEF, RESP_DECERR);
        wait_done();
        rresp_cfg = RESP_OKAY;
        check("t4_err_cnt_2", err_cnt, 2);
        bresp_cfg = RESP_SLVERR;
        for (int n = 0; n < 300; n++) begin
            do_cmd(1, 32'h0C, n, 4'hF, 32'h0, RESP_SLVERR);
            wait_done();
        end
        bresp_cfg = RESP_OKAY;
        check("t4_err_cnt_sat", err_cnt, 255);
        do_cmd(1, 32'h10, 32'h0BADF00D, 4'hF, 32'h0, RESP_OKAY);
        wait_done();
        check("t4_err_cnt_okay_no_inc", err_cnt, 255);

        // 5: consumer stalls the response for 5 cycles
        @(posedge ACLK); #1 rsp_ready = 0;
        do_cmd(0, 32'h04, 32'h0, 4'h0, 32'hDEADBEEF, RESP_OKAY);
        for (int i = 0; i < 100; i++) begin
            if (rsp_valid) break;
            @(negedge ACLK);
        end
        for (int i = 0; i < 5; i++) begin
            check("t5_rsp_valid_held", rsp_valid, 1);
            check("t5_rdata_held", rsp_rdata, 32'hDEADBEEF);
            check("t5_resp_held", rsp_resp, RESP_OKAY);
            check("t5_cmd_ready_low", cmd_ready, 0);
            @(negedge ACLK);
        end
        @(posedge ACLK); #1 rsp_ready = 1;
        wait_done();

        // 6: reset while AWVALID is up
        aw_delay = 20;
        issue(1, 32'h14, 32'hCAFEF00D, 4'hF);
        for (int i = 0; i < 20; i++) begin
            if (AWVALID) break;
            @(negedge ACLK);
        end
        check("t6_awvalid_before_reset", AWVALID, 1);
        @(posedge ACLK); #1 ARESETN = 0;
        @(negedge ACLK);
        check("t6_valids_cleared", {AWVALID, WVALID, ARVALID, BREADY, RREADY, rsp_valid}, 0);
        check("t6_err_cnt_cleared", err_cnt, 0);
        check("t6_awaddr_cleared", AWADDR, 0);
        aw_delay = 0;
        @(posedge ACLK); #1 ARESETN = 1;
        repeat (2) @(negedge ACLK);
        check("t6_cmd_ready_after_release", cmd_ready, 1);
        check("t6_no_stale_request", {AWVALID, WVALID, ARVALID}, 0);
        check("t6_mem_untouched", mem[5], 0);
        do_cmd(0, 32'h04, 32'h0, 4'h0, 32'hDEADBEEF, RESP_OKAY);
        wait_done();

        repeat (3) @(negedge ACLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached, got %0d pending expected 0", exp_q.size());
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
